// File: rtl/dest_drain_arbiter.sv
// dest_drain_arbiter: drains two destination FIFOs (D0/D1) one word at a time
// into a single ready-qualified sink. A four-state FSM (IDLE/POP/LOAD/HOLD)
// keeps at most one word in flight. On a tie, the grant goes round-robin.
// Optional build macro DEST_DRAIN_CNT_EN compiles in per-destination delivered
// word counters; without it, cnt_d0/cnt_d1 are tied to zero.
module dest_drain_arbiter #(
    parameter int WORD_SIZE = 6,
    parameter int CNT_W     = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 d0_empty,
    input  logic                 d1_empty,
    input  logic [WORD_SIZE-1:0] data_in0,
    input  logic [WORD_SIZE-1:0] data_in1,
    input  logic                 sink_ready,
    output logic                 pop_D0,
    output logic                 pop_D1,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic                 dest_sel,
    output logic                 dest_err,
    output logic [CNT_W-1:0]     cnt_d0,
    output logic [CNT_W-1:0]     cnt_d1
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] POP  = 2'd1;
    localparam logic [1:0] LOAD = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    // Bit of the word that names the destination it was routed to
    localparam int DEST_BIT = 4;

    logic [1:0]           state_q, state_d;
    logic                 grant_q, grant_d;
    logic                 last_grant_q, last_grant_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic                 sel_q, sel_d;
    logic                 err_q, err_d;
    logic [WORD_SIZE-1:0] cap_word;
    logic                 xfer_done;

    // Read data from whichever FIFO was popped; valid during LOAD
    assign cap_word  = grant_q ? data_in1 : data_in0;
    assign xfer_done = (state_q == HOLD) && sink_ready;

    // Outputs decode from registered state only, so pops are glitch-free
    assign pop_D0    = (state_q == POP) && !grant_q;
    assign pop_D1    = (state_q == POP) &&  grant_q;
    assign valid_out = (state_q == HOLD);
    assign data_out  = data_q;
    assign dest_sel  = sel_q;
    assign dest_err  = err_q;

    // Next-state, grant selection, and capture of the in-flight word
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        data_d       = data_q;
        sel_d        = sel_q;
        err_d        = err_q;
        case (state_q)
            IDLE: begin
                // Empty flags are looked at only here; later changes cannot disturb a transfer
                if (!d0_empty || !d1_empty) begin
                    state_d = POP;
                    if (!d0_empty && !d1_empty) grant_d = ~last_grant_q;
                    else                        grant_d = d0_empty;
                    last_grant_d = grant_d;
                end
            end
            POP:  state_d = LOAD;
            LOAD: begin
                state_d = HOLD;
                data_d  = cap_word;
                sel_d   = grant_q;
                if (cap_word[DEST_BIT] != grant_q) err_d = 1'b1;
            end
            HOLD: if (sink_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM, grant history and output word registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            data_q       <= '0;
            sel_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
            sel_q        <= sel_d;
            err_q        <= err_d;
        end
    end

`ifdef DEST_DRAIN_CNT_EN
    logic [CNT_W-1:0] cnt_d0_q, cnt_d0_d;
    logic [CNT_W-1:0] cnt_d1_q, cnt_d1_d;

    // Count completed transfers per source; wraps naturally at 2^CNT_W
    always_comb begin
        cnt_d0_d = cnt_d0_q;
        cnt_d1_d = cnt_d1_q;
        if (xfer_done && !grant_q) cnt_d0_d = CNT_W'(cnt_d0_q + 1'b1);
        if (xfer_done &&  grant_q) cnt_d1_d = CNT_W'(cnt_d1_q + 1'b1);
    end

    // Counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_d0_q <= '0;
            cnt_d1_q <= '0;
        end else begin
            cnt_d0_q <= cnt_d0_d;
            cnt_d1_q <= cnt_d1_d;
        end
    end

    assign cnt_d0 = cnt_d0_q;
    assign cnt_d1 = cnt_d1_q;
`else
    logic unused_done;
    assign unused_done = xfer_done;
    assign cnt_d0 = '0;
    assign cnt_d1 = '0;
`endif

endmodule

// File: tb/tb_dest_drain_arbiter.sv
// Directed bench for dest_drain_arbiter. Two queues stand in for the FIFOs:
// read data updates one cycle after a sampled pop. Counter expectations
// follow DEST_DRAIN_CNT_EN.
module tb_dest_drain_arbiter;

`ifdef DEST_DRAIN_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       d0_empty, d1_empty;
    logic [5:0] data_in0, data_in1;
    logic       sink_ready;
    logic       pop_D0, pop_D1;
    logic [5:0] data_out;
    logic       valid_out, dest_sel, dest_err;
    logic [4:0] cnt_d0, cnt_d1;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc_n = 0;
    logic [5:0] q0[$];
    logic [5:0] q1[$];
    int         pop_cyc[$];
    bit         pop_src[$];
    logic [4:0] exp_c0, exp_c1;

    always #5 clk = ~clk;

    dest_drain_arbiter #(.WORD_SIZE(6), .CNT_W(5)) dut (
        .clk(clk), .reset(reset),
        .d0_empty(d0_empty), .d1_empty(d1_empty),
        .data_in0(data_in0), .data_in1(data_in1),
        .sink_ready(sink_ready),
        .pop_D0(pop_D0), .pop_D1(pop_D1),
        .data_out(data_out), .valid_out(valid_out), .dest_sel(dest_sel),
        .dest_err(dest_err), .cnt_d0(cnt_d0), .cnt_d1(cnt_d1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic upd_empty();
        d0_empty = (q0.size() == 0);
        d1_empty = (q1.size() == 0);
    endtask

    task automatic push0(input logic [5:0] w);
        q0.push_back(w);
        upd_empty();
    endtask

    task automatic push1(input logic [5:0] w);
        q1.push_back(w);
        upd_empty();
    endtask

    // One clock: sample pops before the edge, then advance the FIFO models
    task automatic cyc();
        bit p0, p1;
        p0 = pop_D0;
        p1 = pop_D1;
        if (p0 || p1) begin
            pop_cyc.push_back(cyc_n);
            pop_src.push_back(p1);
        end
        @(posedge clk);
        #1;
        cyc_n++;
        if (p0 && q0.size() > 0) data_in0 = q0.pop_front();
        if (p1 && q1.size() > 0) data_in1 = q1.pop_front();
        upd_empty();
    endtask

    task automatic chk_cnt();
        chk("cnt_d0", {27'd0, cnt_d0}, CNT_EN ? {27'd0, exp_c0} : 32'd0);
        chk("cnt_d1", {27'd0, cnt_d1}, CNT_EN ? {27'd0, exp_c1} : 32'd0);
    endtask

    task automatic chk_rst();
        chk("rst_pop",   {30'd0, pop_D0, pop_D1}, 32'd0);
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_data",  {26'd0, data_out}, 32'd0);
        chk("rst_sel",   {31'd0, dest_sel}, 32'd0);
        chk("rst_err",   {31'd0, dest_err}, 32'd0);
        chk("rst_cnt0",  {27'd0, cnt_d0}, 32'd0);
        chk("rst_cnt1",  {27'd0, cnt_d1}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        exp_c0 = '0;
        exp_c1 = '0;
        chk_rst();
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("pop_after_rel", {30'd0, pop_D0, pop_D1}, 32'd0);
    endtask

    // Full transfer from IDLE with sink_ready=1: POP, LOAD, HOLD, accept
    task automatic xfer(input bit src, input logic [5:0] w);
        cyc();
        chk("pop_D0", {31'd0, pop_D0}, {31'd0, !src});
        chk("pop_D1", {31'd0, pop_D1}, {31'd0, src});
        cyc();
        chk("pop_clr", {30'd0, pop_D0, pop_D1}, 32'd0);
        chk("vld_load", {31'd0, valid_out}, 32'd0);
        cyc();
        chk("vld_hold", {31'd0, valid_out}, 32'd1);
        chk("data_out", {26'd0, data_out}, {26'd0, w});
        chk("dest_sel", {31'd0, dest_sel}, {31'd0, src});
        cyc();
        if (src) exp_c1 = exp_c1 + 5'd1;
        else     exp_c0 = exp_c0 + 5'd1;
        chk("vld_done", {31'd0, valid_out}, 32'd0);
        chk_cnt();
    endtask

    initial begin
        reset      = 1'b1;
        sink_ready = 1'b1;
        data_in0   = '0;
        data_in1   = '0;
        exp_c0     = '0;
        exp_c1     = '0;
        upd_empty();
        @(posedge clk);
        #1;

        // Reset state, then single D0 word
        do_reset();
        push0(6'h05);
        xfer(1'b0, 6'h05);
        chk("err_clean", {31'd0, dest_err}, 32'd0);

        // Round-robin on tie, four transfers spaced four cycles apart
        do_reset();
        push0(6'h01); push0(6'h02);
        push1(6'h11); push1(6'h13);
        pop_cyc.delete();
        pop_src.delete();
        xfer(1'b0, 6'h01);
        xfer(1'b1, 6'h11);
        xfer(1'b0, 6'h02);
        xfer(1'b1, 6'h13);
        chk("pop_count", pop_cyc.size(), 32'd4);
        for (int i = 1; i < 4 && i < pop_cyc.size(); i++) begin
            chk("pop_gap", pop_cyc[i] - pop_cyc[i-1], 32'd4);
            chk("pop_order", {31'd0, pop_src[i]}, {31'd0, i[0]});
        end

        // D1 word stalled in HOLD for five cycles; D0 arriving meanwhile is not popped
        push1(6'h12);
        sink_ready = 1'b0;
        cyc();
        chk("stall_pop1", {31'd0, pop_D1}, 32'd1);
        cyc();
        cyc();
        push0(6'h06);
        for (int i = 0; i < 5; i++) begin
            chk("stall_vld", {31'd0, valid_out}, 32'd1);
            chk("stall_data", {26'd0, data_out}, 32'h12);
            chk("stall_nopop", {30'd0, pop_D0, pop_D1}, 32'd0);
            chk_cnt();
            cyc();
        end
        sink_ready = 1'b1;
        cyc();
        exp_c1 = exp_c1 + 5'd1;
        chk("stall_done", {31'd0, valid_out}, 32'd0);
        chk_cnt();
        xfer(1'b0, 6'h06);

        // Routing mismatch sets a sticky error
        push0(6'h10);
        xfer(1'b0, 6'h10);
        chk("err_set", {31'd0, dest_err}, 32'd1);
        push0(6'h05);
        xfer(1'b0, 6'h05);
        chk("err_sticky", {31'd0, dest_err}, 32'd1);
        do_reset();

        // 32 D0 words: counter wraps back to zero
        for (int i = 0; i < 32; i++) begin
            logic [5:0] w;
            w = 6'(i % 16);
            push0(w);
            xfer(1'b0, w);
        end
        chk("cnt0_wrap", {27'd0, cnt_d0}, 32'd0);
        chk("err_wrap", {31'd0, dest_err}, 32'd0);

        // Reset during LOAD clears outputs at once; tie then goes to D0
        do_reset();
        push0(6'h05); push0(6'h07);
        push1(6'h13);
        cyc();
        chk("mid_pop0", {31'd0, pop_D0}, 32'd1);
        cyc();
        #2;
        reset = 1'b1;
        #1;
        exp_c0 = '0;
        exp_c1 = '0;
        chk_rst();
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid_nopop", {30'd0, pop_D0, pop_D1}, 32'd0);
        xfer(1'b0, 6'h07);
        xfer(1'b1, 6'h13);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
